mem_responder: RTL and testbench

- Memory-side responder for the multicycle datapath's memory interface.
- Accepts word read/write requests on memRead/memWrite/addr/data and serves them from a DEPTH-word internal array after a programmable number of wait cycles.
- Signals completion with a one-cycle ready pulse.
- A separate loader port preloads program/data words, replacing hard-wired per-word input buses, so the processor control FSM can be verified against a realistic, variable-latency memory.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath's memory interface (master)
// and mem_responder (slave). Names match the original port list.
interface mem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] dataOut;
  logic        ready;
  logic        err;

  modport master (
    output memRead, memWrite, addr, data,
    input  dataOut, ready, err
  );

  modport slave (
    input  memRead, memWrite, addr, data,
    output dataOut, ready, err
  );
endinterface

// File: rtl/mem_responder.sv
// Variable-latency word memory responder for the multicycle datapath.
// A request is latched in IDLE, waits LATENCY cycles, is performed on the
// following edge and then answered with a one-cycle ready (+err) pulse.
// A loader port writes the array at any time and wins same-edge collisions.
// Optional build macro MEM_ALIGN_CHECK_EN: a misaligned addr (addr[1:0]!=0)
// is flagged as an error in addition to the out-of-range check.
module mem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [31:0]       loadData
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic              req_bad;

  assign bus.dataOut = data_out_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

  // Classify the incoming address: any bit above the word index is out of range.
  always_comb begin
    req_bad = (bus.addr >> (ADDR_W + 2)) != '0;
`ifdef MEM_ALIGN_CHECK_EN
    req_bad = req_bad | (bus.addr[1:0] != 2'b00);
`endif
  end

  // Next-state, access and array-update logic.
  // The loader update is applied last so it overrides a same-index
  // transaction write, while reads always see the pre-edge array.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    bad_d      = bad_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    mem_d      = mem_q;

    unique case (state_q)
      IDLE: begin
        if (bus.memRead | bus.memWrite) begin
          op_wr_d = bus.memWrite;
          idx_d   = bus.addr[ADDR_W+1:2];
          wdata_d = bus.data;
          bad_d   = req_bad;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (op_wr_q) begin
            if (!bad_q) begin
              mem_d[idx_q] = wdata_q;
            end
          end else begin
            data_out_d = bad_q ? '0 : mem_q[idx_q];
          end
          ready_d = 1'b1;
          err_d   = bad_q;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (loadEn) begin
      mem_d[loadAddr] = loadData;
    end
  end

  // Register all state, outputs and the array; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      bad_q      <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      bad_q      <= bad_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed transactions with literal expectations,
// then randomized traffic and loader activity checked every cycle against
// a transaction-level model.
module tb_mem_responder;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              loadEn = 1'b0;
  logic [ADDR_W-1:0] loadAddr = '0;
  logic [31:0]       loadData = '0;
  bit                rand_load = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
  );

  always #5 clk = ~clk;

  initial begin
    bus.memRead = 1'b0;
    bus.memWrite = 1'b0;
    bus.addr = '0;
    bus.data = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [DEPTH];
  logic        m_ready = 1'b0, m_err = 1'b0;
  logic [31:0] m_dout = '0;
  bit          m_valid = 1'b0;
  bit          pend = 1'b0, p_wr, p_bad;
  int          p_idx;
  logic [31:0] p_data;
  longint      edge_n = 0, due = 0, free_at = 0;

  function automatic bit is_bad(input logic [31:0] a);
    bit b;
    b = (a > 32'(DEPTH * 4 - 1));
`ifdef MEM_ALIGN_CHECK_EN
    b = b || (a % 4 != 0);
`endif
    return b;
  endfunction

  // Access happens LATENCY+1 edges after the accept edge; the edge after
  // the access is the response cycle, so a new accept needs a later edge.
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      foreach (mmem[i]) mmem[i] = '0;
      pend = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_dout = '0;
      free_at = edge_n; m_valid = 1'b1;
    end else begin
      m_ready = 1'b0; m_err = 1'b0;
      if (pend && edge_n == due) begin
        if (p_wr) begin
          if (!p_bad) mmem[p_idx] = p_data;
        end else begin
          m_dout = p_bad ? 32'h0 : mmem[p_idx];
        end
        m_ready = 1'b1; m_err = p_bad; pend = 1'b0; free_at = edge_n + 1;
      end else if (!pend && edge_n > free_at && (bus.memRead || bus.memWrite)) begin
        pend = 1'b1; p_wr = bus.memWrite; p_idx = int'((bus.addr / 4) % DEPTH);
        p_data = bus.data; p_bad = is_bad(bus.addr); due = edge_n + LATENCY + 1;
      end
      if (loadEn) mmem[loadAddr] = loadData;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_ready", {31'b0, bus.ready}, {31'b0, m_ready});
      check("cyc_err", {31'b0, bus.err}, {31'b0, m_err});
      check("cyc_dataOut", bus.dataOut, m_dout);
    end
  end

  // Random loader traffic during the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_load) begin
        loadEn = ($urandom_range(0, 3) == 0);
        loadAddr = ADDR_W'($urandom);
        loadData = $urandom;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    loadEn = 1'b1; loadAddr = ADDR_W'(idx); loadData = d;
    sync();
    loadEn = 1'b0;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input bit drop, output logic [31:0] dout, output logic e, output int lat);
    bus.memRead = rd; bus.memWrite = wr; bus.addr = a; bus.data = d;
    lat = 0; dout = '0; e = 1'b0;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      if (lat >= 50) begin
        checks++; failures++;
        $display("FAIL txn_timeout waited=%0d cycles required=ready pulse", lat);
        break;
      end
    end
    dout = bus.dataOut; e = bus.err;
    if (drop) begin bus.memRead = 1'b0; bus.memWrite = 1'b0; end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd_v;
  logic        e_v;
  int          lat_v;
  logic [31:0] exp_words [DEPTH];

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, bus.ready}, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    check("rst_dataOut", bus.dataOut, 32'h0);
    sync();

    // Preloaded read with latency check
    load(3, 32'h1234_5678);
    txn(1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("rd3_data", rd_v, 32'h1234_5678);
    check("rd3_err", {31'b0, e_v}, 32'h0);
    check("rd3_latency", lat_v, 32'd4);
    @(negedge clk);
    check("rd3_ready_one_cycle", {31'b0, bus.ready}, 32'h0);
    sync();

    // Write holds dataOut, then read back
    txn(1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 1'b1, rd_v, e_v, lat_v);
    check("wr5_dataOut_held", rd_v, 32'h1234_5678);
    check("wr5_err", {31'b0, e_v}, 32'h0);
    sync();
    txn(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("rd5_data", rd_v, 32'hCAFE_F00D);
    sync();

    // Out-of-range read and write
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("oor_rd_err", {31'b0, e_v}, 32'h1);
    check("oor_rd_data", rd_v, 32'h0);
    sync();
    txn(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, rd_v, e_v, lat_v);
    check("oor_wr_err", {31'b0, e_v}, 32'h1);
    sync();
    foreach (exp_words[i]) exp_words[i] = '0;
    exp_words[3] = 32'h1234_5678;
    exp_words[5] = 32'hCAFE_F00D;
    for (int i = 0; i < int'(DEPTH); i++) begin
      txn(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, rd_v, e_v, lat_v);
      check($sformatf("scan_w%0d", i), rd_v, exp_words[i]);
      sync();
    end

    // Both request lines high: write wins
    txn(1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5, 1'b1, rd_v, e_v, lat_v);
    check("both_err", {31'b0, e_v}, 32'h0);
    sync();
    txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("both_readback", rd_v, 32'hA5A5_A5A5);
    sync();

    // Misaligned read
    load(1, 32'h1111_2222);
    txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, 1'b1, rd_v, e_v, lat_v);
`ifdef MEM_ALIGN_CHECK_EN
    check("align_err", {31'b0, e_v}, 32'h1);
    check("align_data", rd_v, 32'h0);
`else
    check("align_err", {31'b0, e_v}, 32'h0);
    check("align_data", rd_v, 32'h1111_2222);
`endif
    sync();

    // Loader beats a same-edge transaction write
    loadEn = 1'b1; loadAddr = 5'd7; loadData = 32'h0000_00BB;
    txn(1'b0, 1'b1, 32'h0000_001C, 32'h0000_0077, 1'b1, rd_v, e_v, lat_v);
    loadEn = 1'b0;
    sync();
    txn(1'b1, 1'b0, 32'h0000_001C, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("load_wins", rd_v, 32'h0000_00BB);
    sync();

    // Reset during WAIT aborts the write
    load(2, 32'h2222_0000);
    bus.memWrite = 1'b1; bus.addr = 32'h8; bus.data = 32'h0000_0088;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1; bus.memWrite = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_ready", {31'b0, bus.ready}, 32'h0);
    end
    check("abort_dataOut", bus.dataOut, 32'h0);
    sync();
    txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, rd_v, e_v, lat_v);
    check("abort_mem2", rd_v, 32'h0);
    check("abort_latency", lat_v, 32'd4);
    sync();

    // Randomized traffic, including back-to-back requests
    rand_load = 1'b1;
    sync();
    for (int n = 0; n < 150; n++) begin
      int unsigned r, sel;
      logic [31:0] a;
      r = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel == 0) a = $urandom;
      else if (sel == 1) a = {25'b0, 5'($urandom), 2'($urandom)};
      else a = {25'b0, 5'($urandom), 2'b00};
      txn(r != 1, r != 0, a, $urandom, 1'b0, rd_v, e_v, lat_v);
      if ($urandom_range(0, 1) == 0 || n == 149) begin
        bus.memRead = 1'b0; bus.memWrite = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        sync();
      end
    end
    rand_load = 1'b0;
    sync();
    loadEn = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
